// File: rtl/router_input_unit_if.sv
// Link between an upstream output stage and a router input unit.
// master = upstream/driver side, slave = input unit.
interface router_input_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_data_valid;
    logic             deq;
    logic [WIDTH-1:0] head_data;
    logic             head_valid;
    logic             credit_out;
    logic [OCC_W-1:0] occupancy;
    logic             overflow_err;
    logic             underflow_err;

    modport master (
        output in_data, in_data_valid, deq,
        input  head_data, head_valid, credit_out, occupancy, overflow_err, underflow_err
    );

    modport slave (
        input  in_data, in_data_valid, deq,
        output head_data, head_valid, credit_out, occupancy, overflow_err, underflow_err
    );
endinterface

// File: rtl/router_input_unit.sv
// Quadtree router input unit: credit-returning flit FIFO of DEPTH entries.
// Define INPUT_UNIT_ERR_CHECK_EN to build the sticky overflow/underflow flags.
`ifndef LEVEL_ROOT
`define LEVEL_ROOT 0
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 0
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module router_input_unit #(
    parameter int LEVEL     = `LEVEL_ROOT,
    parameter int DIRECTION = `DIR_LOCAL,
    parameter int DEPTH     = `ROUTER_FIFO_DEPTH,
    parameter int WIDTH     = `ROUTER_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    router_input_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Elaboration-only hook keeping the informational parameters referenced.
    if (DEPTH < 2 || LEVEL < 0 || DIRECTION < 0) begin : g_invalid_cfg
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             credit_q, credit_d;
    logic             head_valid;
    logic             full;
    logic             deq_eff;
    logic             enq;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_valid = (occ_q != '0);
        full       = (occ_q == OCC_W'(DEPTH));
        deq_eff    = bus.deq & head_valid;
        enq        = bus.in_data_valid & (~full | deq_eff);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        credit_d = deq_eff;

        if (enq) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (deq_eff) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (enq && !deq_eff) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!enq && deq_eff) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef INPUT_UNIT_ERR_CHECK_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.in_data_valid & full & ~deq_eff);
        unf_d = unf_q | (bus.deq & ~head_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
`else
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif

    assign bus.head_valid = head_valid;
    assign bus.head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.credit_out = credit_q;
    assign bus.occupancy  = occ_q;
endmodule
